// File: rtl/chunked_add_sequencer.sv
// ---------------------------------------------------------------------------
// chunked_add_sequencer
//
// Computes {cout, sum} = a + b + cin over WIDTH bits using one CHUNK-bit
// adder slice. The slice is reused once per cycle, least-significant chunk
// first, and the carry between chunks is kept in a register. Operands are
// captured at accept, so the producer may change them freely afterwards.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      a, b, cin are valid
//   in_ready   out  1      operands accepted this cycle (IDLE, not in reset)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in
//   abort      in   1      cancel in-flight operation; blocks accept in IDLE
//   out_valid  out  1      sum / cout valid (DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  result bits [WIDTH-1:0]
//   cout       out  1      carry out of bit WIDTH-1 (2^WIDTH weight)
//   busy       out  1      state is not IDLE
// ---------------------------------------------------------------------------
module chunked_add_sequencer #(
  parameter int WIDTH = 65,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  // Operands are stored zero-padded up to a whole number of chunks.
  localparam int PW     = NCHUNK * CHUNK;
  localparam int R      = WIDTH % CHUNK;
  // With a partial top chunk the 2^WIDTH bit lands inside the slice result
  // at position R; otherwise it is the slice carry-out.
  localparam int COUT_BIT = (R == 0) ? CHUNK : R;
  localparam int IW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [PW-1:0]     a_r;
  logic [PW-1:0]     b_r;
  logic              carry_r;
  logic [IW-1:0]     idx_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              out_valid_r;
  logic              busy_r;

  logic              accept_s;
  logic [CHUNK-1:0]  a_chunk_s;
  logic [CHUNK-1:0]  b_chunk_s;
  logic [CHUNK:0]    slice_s;
  logic [31:0]       off_s;
  logic [WIDTH-1:0]  chunk_ext_s;
  logic [WIDTH-1:0]  chunk_mask_s;
  logic [WIDTH-1:0]  sum_next_s;

  // Handshake: ready only in IDLE and never while reset is asserted; abort
  // wins over a valid operand in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    accept_s = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
    accept_s = in_valid & in_ready & ~abort;
  end

  // Select the current chunk of each operand with a constant-index mux.
  always_comb begin
    a_chunk_s = {CHUNK{1'b0}};
    b_chunk_s = {CHUNK{1'b0}};
    for (int i = 0; i < NCHUNK; i++) begin
      a_chunk_s = (idx_r == IW'(i)) ? a_r[i*CHUNK +: CHUNK] : a_chunk_s;
      b_chunk_s = (idx_r == IW'(i)) ? b_r[i*CHUNK +: CHUNK] : b_chunk_s;
    end
  end

  // The shared adder slice and the merge of its result into the sum.
  // Shifting within a WIDTH-wide vector drops top-chunk bits above WIDTH-1.
  always_comb begin
    slice_s      = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    off_s        = 32'(idx_r) * 32'(CHUNK);
    chunk_ext_s  = WIDTH'(slice_s[CHUNK-1:0]) << off_s;
    chunk_mask_s = WIDTH'({CHUNK{1'b1}}) << off_s;
    sum_next_s   = (sum_r & ~chunk_mask_s) | chunk_ext_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
        end else if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; out_valid and busy are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // Datapath: operand capture at accept, then one chunk per RUN cycle.
  // An aborted RUN cycle writes nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {PW{1'b0}};
      b_r     <= {PW{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= PW'(a);
            b_r     <= PW'(b);
            carry_r <= cin;
            idx_r   <= {IW{1'b0}};
          end
        end
        RUN: begin
          if (!abort) begin
            sum_r   <= sum_next_s;
            carry_r <= slice_s[CHUNK];
            if (idx_r == LAST_IDX) begin
              cout_r <= slice_s[COUT_BIT];
            end else begin
              idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            end
          end
        end
        DONE: begin
          carry_r <= carry_r;
        end
        default: begin
          idx_r <= {IW{1'b0}};
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
module tb_chunked_add_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, cin, abort, out_ready;
  logic [64:0] a, b;
  logic        in_ready, out_valid, cout, busy;
  logic [64:0] sum;

  // Sweep instances (CHUNK = 65, 1, 13) share operands, each has its own valid.
  logic        sw_in_valid [3];
  logic [64:0] sw_a, sw_b;
  logic        sw_cin;
  logic        sw_in_ready [3];
  logic        sw_out_valid[3];
  logic        sw_cout     [3];
  logic        sw_busy     [3];
  logic [64:0] sw_sum      [3];

  int checks = 0;
  int errors = 0;

  chunked_add_sequencer #(.WIDTH(65), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy));

  chunked_add_sequencer #(.WIDTH(65), .CHUNK(65)) dut_c65 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .abort(1'b0), .out_valid(sw_out_valid[0]),
    .out_ready(1'b1), .sum(sw_sum[0]), .cout(sw_cout[0]), .busy(sw_busy[0]));

  chunked_add_sequencer #(.WIDTH(65), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .abort(1'b0), .out_valid(sw_out_valid[1]),
    .out_ready(1'b1), .sum(sw_sum[1]), .cout(sw_cout[1]), .busy(sw_busy[1]));

  chunked_add_sequencer #(.WIDTH(65), .CHUNK(13)) dut_c13 (
    .clk(clk), .rst(rst), .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .abort(1'b0), .out_valid(sw_out_valid[2]),
    .out_ready(1'b1), .sum(sw_sum[2]), .cout(sw_cout[2]), .busy(sw_busy[2]));

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one cycle in IDLE; returns just after the accept edge.
  task automatic start_op(input logic [64:0] va, input logic [64:0] vb, input logic vc);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges until out_valid rises, or -1 if it does not within the budget.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 65'd0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_all_ones();
    int lat;
    out_ready = 1'b1;
    start_op({65{1'b1}}, 65'd1, 1'b0);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL ones_busy: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait_done(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL ones_latency: got %0d want 5", lat); end
    checks++; if (sum !== 65'd0 || cout !== 1'b1) begin errors++; $display("FAIL ones_result: got %b_%h want 1_0", cout, sum); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ones_return_idle: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_carry_chain();
    int lat;
    start_op(65'h0_0000_FFFF_0000_FFFF, 65'h0_0000_0001_0000_0001, 1'b1);
    wait_done(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL chain_latency: got %0d want 5", lat); end
    checks++; if (sum !== 65'h0_0001_0000_0001_0001 || cout !== 1'b0) begin errors++; $display("FAIL chain_result: got %b_%h want 0_00001000000010001", cout, sum); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start_op(65'd100, 65'd23, 1'b1);
    wait_done(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL bp_latency: got %0d want 5", lat); end
    a = 65'd5; b = 65'd6; cin = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ctrl: got out_valid=%b in_ready=%b want 1/0", out_valid, in_ready); end
      checks++; if (sum !== 65'd124 || cout !== 1'b0) begin errors++; $display("FAIL bp_hold_result: got %b_%h want 0_7c", cout, sum); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ov=%b busy=%b ir=%b want 0/0/1", out_valid, busy, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got busy=%b want 1", busy); end
    wait_done(lat);
    checks++; if (lat != 5 || sum !== 65'd11 || cout !== 1'b0) begin errors++; $display("FAIL bp_next_result: got lat=%0d %b_%h want 5 0_b", lat, cout, sum); end
    tick();
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    out_ready = 1'b1;
    start_op({65{1'b1}}, 65'd1, 1'b0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b ov=%b want 0/0", busy, out_valid); end
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); end
    // abort in IDLE blocks acceptance
    a = 65'd1; b = 65'd1; cin = 1'b0; in_valid = 1'b1; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_blocks_accept: got busy=%b want 0", busy); end
    start_op(65'd5, 65'd7, 1'b0);
    wait_done(lat);
    checks++; if (lat != 5 || sum !== 65'd12 || cout !== 1'b0) begin errors++; $display("FAIL abort_next_result: got lat=%0d %b_%h want 5 0_c", lat, cout, sum); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    start_op(65'h1234, 65'h1111, 1'b0);
    tick(); tick();
    checks++; if (sum[15:0] !== 16'h2345) begin errors++; $display("FAIL midrun_partial: got %h want 2345", sum[15:0]); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || sum !== 65'd0 || cout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_reset: got ov=%b sum=%h cout=%b busy=%b want 0/0/0/0", out_valid, sum, cout, busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrun_in_ready_rst: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int n;
    int lat;
    logic prev_busy;
    out_ready = 1'b1;
    a = 65'd10; b = 65'd20; cin = 1'b0; in_valid = 1'b1;
    tick();
    n = 0;
    prev_busy = busy;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (!prev_busy && busy) begin
        n = c;
        break;
      end
      prev_busy = busy;
    end
    in_valid = 1'b0;
    checks++; if (n != 7) begin errors++; $display("FAIL b2b_period: got %0d want 7", n); end
    wait_done(lat);
    checks++; if (sum !== 65'd30 || cout !== 1'b0) begin errors++; $display("FAIL b2b_result: got %b_%h want 0_1e", cout, sum); end
    tick();
  endtask

  task automatic test_sweep(input int k, input int exp_lat, input int nops);
    logic [95:0] r;
    logic [65:0] exp_v;
    int lat;
    for (int n = 0; n < nops; n++) begin
      if (n == 0) begin
        sw_a = {65{1'b1}}; sw_b = 65'd1; sw_cin = 1'b0;
      end else if (n == 1) begin
        sw_a = {65{1'b1}}; sw_b = {65{1'b1}}; sw_cin = 1'b1;
      end else begin
        r = {$urandom, $urandom, $urandom}; sw_a = r[64:0];
        r = {$urandom, $urandom, $urandom}; sw_b = r[64:0];
        sw_cin = 1'($urandom_range(0, 1));
      end
      exp_v = {1'b0, sw_a} + {1'b0, sw_b} + {65'd0, sw_cin};
      sw_in_valid[k] = 1'b1;
      tick();
      sw_in_valid[k] = 1'b0;
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
        tick();
        if (sw_out_valid[k]) begin
          lat = c;
          break;
        end
      end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL sweep%0d_latency: got %0d want %0d", k, lat, exp_lat); end
      checks++; if ({sw_cout[k], sw_sum[k]} !== exp_v) begin errors++; $display("FAIL sweep%0d_result: got %h want %h", k, {sw_cout[k], sw_sum[k]}, exp_v); end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) sw_in_valid[k] = 1'b0;
    sw_a = '0; sw_b = '0; sw_cin = 1'b0;
    test_reset();
    test_all_ones();
    test_carry_chain();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep(0, 1, 300);
    test_sweep(1, 65, 300);
    test_sweep(2, 5, 300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
